// File: rtl/num_to_ascii_stream.sv
// Binary integer to ASCII decimal byte stream: sequential double-dabble, then one byte per handshake.
// Optional macro ASCII_NEWLINE_EN appends a 0x0A byte (carrying out_last) after the final digit.
module num_to_ascii_stream #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned NUM_DIGITS = 5,
   parameter int unsigned SIGNED     = 1,
   parameter int unsigned ZERO_PAD   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_char,
   output logic              out_last
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(DATA_W);
`ifdef ASCII_NEWLINE_EN
   localparam logic HAS_LF = 1'b1;
`else
   localparam logic HAS_LF = 1'b0;
`endif

   // Decimal digits needed for the largest unsigned DATA_W-bit value.
   function automatic int unsigned dec_digits(input int unsigned w);
      longint unsigned v;
      int unsigned     n;
      v = (64'd1 << w) - 64'd1;
      n = 0;
      while (v != 64'd0) begin
         v = v / 64'd10;
         n = n + 1;
      end
      return n;
   endfunction

   localparam int unsigned MIN_DIGITS = dec_digits(DATA_W);

   generate
      if (DATA_W < 4 || DATA_W > 32) begin : g_bad_width
         $error("num_to_ascii_stream: DATA_W must be within 4..32");
      end
      if (NUM_DIGITS < MIN_DIGITS) begin : g_bad_digits
         $error("num_to_ascii_stream: NUM_DIGITS too small for DATA_W");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      EMIT_SIGN,
      EMIT_DIG
`ifdef ASCII_NEWLINE_EN
      , EMIT_LF
`endif
   } state_t;

   // One shift-and-add-3 step with the next magnitude bit shifted in.
   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
      logic [BCD_W-1:0] a;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         a[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
      end
      return BCD_W'({a, bit_in});
   endfunction

   function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] i);
      logic [3:0] d;
      d = 4'd0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (i == IDX_W'(k)) d = b[4*k +: 4];
      end
      return d;
   endfunction

   // Highest digit to emit: top slot when padding, else highest nonzero (digit 0 for zero).
   function automatic logic [IDX_W-1:0] first_digit(input logic [BCD_W-1:0] b);
      logic [IDX_W-1:0] s;
      s = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (ZERO_PAD != 0 || b[4*k +: 4] != 4'd0) s = IDX_W'(k);
      end
      return s;
   endfunction

   function automatic logic [7:0] ascii(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   state_t            state, state_n;
   logic              neg, neg_n;
   logic [DATA_W-1:0] mag, mag_n;
   logic [BCD_W-1:0]  bcd, bcd_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic              out_valid_n;
   logic              out_last_n;
   logic [7:0]        out_char_n;
   logic [BCD_W-1:0]  step;
   logic [IDX_W-1:0]  start;

   assign in_ready = (state == IDLE) && !reset;

   // Next-state and next-output logic; the emit bytes are prepared one cycle ahead.
   always_comb begin
      state_n     = state;
      neg_n       = neg;
      mag_n       = mag;
      bcd_n       = bcd;
      cnt_n       = cnt;
      idx_n       = idx;
      out_valid_n = out_valid;
      out_char_n  = out_char;
      out_last_n  = out_last;
      step        = dabble(bcd, mag[DATA_W-1]);
      start       = first_digit(step);

      case (state)
         IDLE: begin
            if (in_valid) begin
               neg_n   = (SIGNED != 0) && in_data[DATA_W-1];
               mag_n   = neg_n ? (~in_data + DATA_W'(1)) : in_data;
               bcd_n   = '0;
               cnt_n   = '0;
               state_n = CONVERT;
            end
         end

         CONVERT: begin
            bcd_n = step;
            mag_n = {mag[DATA_W-2:0], 1'b0};
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
               idx_n       = start;
               out_valid_n = 1'b1;
               if (neg) begin
                  state_n    = EMIT_SIGN;
                  out_char_n = 8'h2D;
                  out_last_n = 1'b0;
               end else begin
                  state_n    = EMIT_DIG;
                  out_char_n = ascii(digit_at(step, start));
                  out_last_n = (start == '0) && !HAS_LF;
               end
            end
         end

         EMIT_SIGN: begin
            if (out_ready) begin
               state_n    = EMIT_DIG;
               out_char_n = ascii(digit_at(bcd, idx));
               out_last_n = (idx == '0) && !HAS_LF;
            end
         end

         EMIT_DIG: begin
            if (out_ready) begin
               if (idx != '0) begin
                  idx_n      = idx - IDX_W'(1);
                  out_char_n = ascii(digit_at(bcd, idx_n));
                  out_last_n = (idx_n == '0) && !HAS_LF;
               end else begin
`ifdef ASCII_NEWLINE_EN
                  state_n    = EMIT_LF;
                  out_char_n = 8'h0A;
                  out_last_n = 1'b1;
`else
                  state_n     = IDLE;
                  out_valid_n = 1'b0;
                  out_last_n  = 1'b0;
`endif
               end
            end
         end

`ifdef ASCII_NEWLINE_EN
         EMIT_LF: begin
            if (out_ready) begin
               state_n     = IDLE;
               out_valid_n = 1'b0;
               out_last_n  = 1'b0;
            end
         end
`endif

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         neg       <= 1'b0;
         mag       <= '0;
         bcd       <= '0;
         cnt       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_char  <= 8'h00;
         out_last  <= 1'b0;
      end else begin
         state     <= state_n;
         neg       <= neg_n;
         mag       <= mag_n;
         bcd       <= bcd_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         out_valid <= out_valid_n;
         out_char  <= out_char_n;
         out_last  <= out_last_n;
      end
   end

endmodule

// File: tb/tb_num_to_ascii_stream.sv
// Randomised bench for num_to_ascii_stream: a signed/unpadded and an unsigned/zero-padded instance
// share stimulus and are checked every cycle against a string-formatting reference model.
module tb_num_to_ascii_stream;

   localparam int unsigned DW = 16;
   localparam int unsigned ND = 5;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [DW-1:0] in_data;
   logic       out_ready;
   logic [1:0] in_ready_v;
   logic [1:0] out_valid_v;
   logic [1:0] out_last_v;
   logic [7:0] out_char_v [2];

   int    n_pass;
   int    n_total;
   bit    model_on;
   int    hs_cnt [2];
   string log_s [2];

   num_to_ascii_stream #(.DATA_W(DW), .NUM_DIGITS(ND), .SIGNED(1), .ZERO_PAD(0)) u_dut_s (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_data(in_data),
      .out_valid(out_valid_v[0]), .out_ready(out_ready),
      .out_char(out_char_v[0]), .out_last(out_last_v[0])
   );

   num_to_ascii_stream #(.DATA_W(DW), .NUM_DIGITS(ND), .SIGNED(0), .ZERO_PAD(1)) u_dut_u (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_data(in_data),
      .out_valid(out_valid_v[1]), .out_ready(out_ready),
      .out_char(out_char_v[1]), .out_last(out_last_v[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic string hexs(input string s);
      string r;
      r = "";
      for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s.getc(i))};
      return r;
   endfunction

   task automatic check_s(input string name, input string act, input string exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got [%s] expected [%s]", name, hexs(act), hexs(exp));
   endtask

   // Reference: the text a value must produce, built with ordinary decimal formatting.
   function automatic string model_str(input logic [DW-1:0] v, input bit sgn, input bit zp);
      longint unsigned m;
      bit              neg;
      string           s;
      neg = sgn && v[DW-1];
      m   = neg ? ((64'd1 << DW) - 64'(v)) : 64'(v);
      s   = $sformatf("%0d", m);
      while (zp && s.len() < ND) s = {"0", s};
      if (neg) s = {"-", s};
`ifdef ASCII_NEWLINE_EN
      s = {s, "\n"};
`endif
      return s;
   endfunction

   // Expected transfer log for one value: its bytes, then '$' marking out_last.
   function automatic string lit(input string s);
`ifdef ASCII_NEWLINE_EN
      return {s, "\n$"};
`else
      return {s, "$"};
`endif
   endfunction

   // Per-cycle compare at the falling edge; also predicts what the next rising edge does.
   initial begin : compare
      int    cyc;
      int    valid_at [2];
      bit    busy [2];
      int    pos [2];
      string exp_s [2];
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
         busy[k] = 1'b0; pos[k] = 0; valid_at[k] = 0; exp_s[k] = ""; hs_cnt[k] = 0; log_s[k] = "";
      end
      wait (model_on);
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            bit ev;
            check($sformatf("in_ready[%0d]", k), longint'(in_ready_v[k]), longint'(!busy[k] && !reset));
            ev = busy[k] && (cyc >= valid_at[k]);
            check($sformatf("out_valid[%0d]", k), longint'(out_valid_v[k]), longint'(ev));
            if (ev) begin
               check($sformatf("out_char[%0d]", k), longint'(out_char_v[k]),
                     longint'(exp_s[k].getc(pos[k])));
               check($sformatf("out_last[%0d]", k), longint'(out_last_v[k]),
                     longint'(pos[k] == exp_s[k].len() - 1));
            end
            if (reset) begin
               busy[k] = 1'b0;
            end else if (ev && out_ready) begin
               log_s[k] = $sformatf("%s%c", log_s[k], out_char_v[k]);
               if (out_last_v[k]) log_s[k] = {log_s[k], "$"};
               pos[k]++;
               if (pos[k] >= exp_s[k].len()) busy[k] = 1'b0;
            end else if (!busy[k] && in_valid) begin
               busy[k]     = 1'b1;
               valid_at[k] = cyc + 1 + DW;
               exp_s[k]    = model_str(in_data, k == 0, k == 1);
               pos[k]      = 0;
               hs_cnt[k]++;
            end
         end
      end
   end

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         ok = (in_ready_v == 2'b11);
      end
      check("idle_wait", longint'(ok), 1);
   endtask

   task automatic send(input logic [DW-1:0] v);
      wait_idle();
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic clear_logs();
      log_s[0] = "";
      log_s[1] = "";
   endtask

   task automatic run_one(input logic [DW-1:0] v, input string exp0, input string exp1, input string tag);
      clear_logs();
      send(v);
      wait_idle();
      check_s({tag, "_signed"}, log_s[0], lit(exp0));
      check_s({tag, "_zpad"}, log_s[1], lit(exp1));
   endtask

   initial begin : stim
      int         lat;
      int         base0;
      int         base1;
      bit         got;
      logic [5:0] pat;
      n_pass    = 0;
      n_total   = 0;
      model_on  = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      pat       = 6'b101001;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_on = 1'b1;

      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_out_valid[%0d]", k), longint'(out_valid_v[k]), 0);
         check($sformatf("rst_out_char[%0d]", k), longint'(out_char_v[k]), 0);
         check($sformatf("rst_out_last[%0d]", k), longint'(out_last_v[k]), 0);
         check($sformatf("rst_in_ready[%0d]", k), longint'(in_ready_v[k]), 1);
      end

      // 1234: first byte in the 17th cycle after the handshake cycle.
      clear_logs();
      send(16'd1234);
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         lat++;
         got = out_valid_v[0];
      end
      check("latency_1234", longint'(lat), 17);
      wait_idle();
      check_s("v1234_signed", log_s[0], lit("1234"));
      check_s("v1234_zpad", log_s[1], lit("01234"));

      run_one(16'd0,     "0",      "00000", "v0");
      run_one(16'hFFFF,  "-1",     "65535", "vffff");
      run_one(16'h8000,  "-32768", "32768", "v8000");
      run_one(16'd42,    "42",     "00042", "v42");

      // Backpressure with in_valid held high across two values.
      wait_idle();
      clear_logs();
      base0 = hs_cnt[0];
      base1 = hs_cnt[1];
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_data   = 16'd9876;
      out_ready = pat[0];
      got = 1'b0;
      for (int i = 1; i < 600 && !got; i++) begin
         @(posedge clk); #1;
         out_ready = pat[i % 6];
         if (hs_cnt[0] >= base0 + 1 && hs_cnt[1] >= base1 + 1) in_data = 16'hFFFB;
         if (hs_cnt[0] >= base0 + 2 && hs_cnt[1] >= base1 + 2) got = 1'b1;
      end
      in_valid = 1'b0;
      check("bp_second_accept", longint'(got), 1);
      got = 1'b0;
      for (int i = 0; i < 600 && !got; i++) begin
         @(posedge clk); #1;
         out_ready = pat[i % 6];
         got = (in_ready_v == 2'b11);
      end
      out_ready = 1'b1;
      wait_idle();
      check_s("bp_signed", log_s[0], {lit("9876"), lit("-5")});
      check_s("bp_zpad", log_s[1], {lit("09876"), lit("65531")});

      // Reset after two bytes of 12345 aborts the value.
      clear_logs();
      send(16'd12345);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = out_valid_v[0];
      end
      check("rst_test_start", longint'(got), 1);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("abort_out_valid[%0d]", k), longint'(out_valid_v[k]), 0);
         check($sformatf("abort_out_char[%0d]", k), longint'(out_char_v[k]), 0);
         check($sformatf("abort_in_ready[%0d]", k), longint'(in_ready_v[k]), 1);
      end
      check_s("abort_signed", log_s[0], "12");
      check_s("abort_zpad", log_s[1], "12");
      run_one(16'd7, "7", "00007", "v7");

      // Random traffic, corner-biased data, random backpressure and rare resets.
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         reset     = ($urandom_range(0, 399) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       in_data = 16'd0;
            1:       in_data = 16'h8000;
            2:       in_data = 16'hFFFF;
            3:       in_data = DW'($urandom_range(0, 9));
            4:       in_data = 16'h7FFF;
            default: in_data = DW'($urandom);
         endcase
      end
      @(posedge clk); #1;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
